// File: rtl/pixel_window_pkg.sv
// Shared widths, window geometry and FSM encoding for the sliding-window streamer.
package pixel_window_pkg;

    localparam int DWIDTH   = 16;
    localparam int LWIDTH   = 8;
    localparam int FSIZE    = 5;
    localparam int MAXWIDTH = 64;
    localparam int AWIDTH   = $clog2(MAXWIDTH);
    localparam int NTAPS    = FSIZE * FSIZE;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_STREAM = 2'd1;
    localparam state_t ST_FLUSH  = 2'd2;

endpackage

// File: rtl/pixel_window_line_ram.sv
// Single-port line buffer: read-before-write with a registered read port.
module line_ram
    import pixel_window_pkg::*;
#(
    parameter int DEPTH = MAXWIDTH,
    parameter int WIDTH = DWIDTH
)
(
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic signed [WIDTH-1:0]  wdata,
    output logic signed [WIDTH-1:0]  rdata
);

    logic signed [WIDTH-1:0] mem [DEPTH];
    logic signed [WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (en) begin
            rdata_reg <= mem[addr];
            if (we) begin
                mem[addr] <= wdata;
            end
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/pixel_window.sv
// Streams an N x N frame in raster order and emits every FSIZE x FSIZE window
// (stride 1, no padding) one cycle after the pixel that completes it is accepted.
module pixel_window
    import pixel_window_pkg::*;
(
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     start,
    input  logic [LWIDTH-1:0]        img_size,
    input  logic                     in_valid,
    input  logic signed [DWIDTH-1:0] in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic signed [DWIDTH-1:0] pixel [NTAPS],
    output logic                     busy,
    output logic                     done
);

    state_t                  state_reg;
    logic [LWIDTH-1:0]       size_reg;
    logic [LWIDTH-1:0]       col_reg;
    logic [LWIDTH-1:0]       row_reg;
    logic [AWIDTH-1:0]       ptr_reg;
    logic                    out_valid_reg;
    logic signed [DWIDTH-1:0] win_reg   [NTAPS];
    logic signed [DWIDTH-1:0] win_next  [NTAPS];
    logic signed [DWIDTH-1:0] pixel_reg [NTAPS];
    logic signed [DWIDTH-1:0] buf_wdata [FSIZE-1];
    logic signed [DWIDTH-1:0] buf_rdata [FSIZE-1];
    logic                    accept;
    logic                    last_pix;
    logic                    win_ok;

    assign in_ready = (state_reg == ST_STREAM);
    assign busy     = (state_reg != ST_IDLE);
    assign done     = (state_reg == ST_FLUSH);
    assign accept   = in_valid && in_ready;
    assign last_pix = (row_reg == size_reg - 1'b1) && (col_reg == size_reg - 1'b1);
    assign win_ok   = (row_reg >= LWIDTH'(FSIZE - 1)) && (col_reg >= LWIDTH'(FSIZE - 1));

    // The buffers cycle through N-1 addresses, not N: the registered read adds the
    // last cycle of the one-row delay, so the value above is ready in the accept cycle.
    genvar gi, gj;
    generate
        for (gi = 0; gi < FSIZE - 1; gi++) begin : g_line
            if (gi == 0) begin : g_head
                assign buf_wdata[gi] = in_data;
            end else begin : g_tail
                assign buf_wdata[gi] = buf_rdata[gi-1];
            end
            line_ram #(.DEPTH(MAXWIDTH), .WIDTH(DWIDTH)) u_line_ram (
                .clk   (clk),
                .en    (accept),
                .we    (accept),
                .addr  (ptr_reg),
                .wdata (buf_wdata[gi]),
                .rdata (buf_rdata[gi])
            );
        end

        for (gi = 0; gi < FSIZE; gi++) begin : g_row
            for (gj = 0; gj < FSIZE; gj++) begin : g_col
                if (gj < FSIZE - 1) begin : g_shift
                    assign win_next[gi*FSIZE+gj] = win_reg[gi*FSIZE+gj+1];
                end else if (gi < FSIZE - 1) begin : g_from_buf
                    assign win_next[gi*FSIZE+gj] = buf_rdata[FSIZE-2-gi];
                end else begin : g_from_input
                    assign win_next[gi*FSIZE+gj] = in_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_reg     <= ST_IDLE;
            size_reg      <= '0;
            col_reg       <= '0;
            row_reg       <= '0;
            ptr_reg       <= '0;
            out_valid_reg <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                win_reg[i]   <= '0;
                pixel_reg[i] <= '0;
            end
        end else begin
            out_valid_reg <= accept && win_ok;
            for (int i = 0; i < NTAPS; i++) begin
                pixel_reg[i] <= (accept && win_ok) ? win_next[i] : '0;
                if (accept) begin
                    win_reg[i] <= win_next[i];
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        size_reg  <= img_size;
                        col_reg   <= '0;
                        row_reg   <= '0;
                        ptr_reg   <= '0;
                        state_reg <= (img_size >= LWIDTH'(FSIZE)) ? ST_STREAM : ST_FLUSH;
                    end
                end
                ST_STREAM: begin
                    if (accept) begin
                        if (col_reg == size_reg - 1'b1) begin
                            col_reg <= '0;
                            row_reg <= row_reg + 1'b1;
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                        ptr_reg <= (ptr_reg == AWIDTH'(size_reg - LWIDTH'(2))) ? '0 : ptr_reg + 1'b1;
                        if (last_pix) begin
                            state_reg <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: state_reg <= ST_IDLE;
                default:  state_reg <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign pixel     = pixel_reg;

endmodule

// File: tb/tb_pixel_window.sv
// Self-checking bench: every accepted pixel is stored in a frame image and each
// expected window is sliced straight out of that image by (row, col) arithmetic.
module tb_pixel_window;
    import pixel_window_pkg::*;

    localparam int F = FSIZE;

    logic                     clk = 1'b0;
    logic                     xrst = 1'b0;
    logic                     start = 1'b0;
    logic [LWIDTH-1:0]        img_size = '0;
    logic                     in_valid = 1'b0;
    logic signed [DWIDTH-1:0] in_data = '0;
    logic                     in_ready;
    logic                     out_valid;
    logic signed [DWIDTH-1:0] pixel [F*F];
    logic                     busy;
    logic                     done;

    pixel_window dut (
        .clk       (clk),
        .xrst      (xrst),
        .start     (start),
        .img_size  (img_size),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .pixel     (pixel),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic signed [DWIDTH-1:0] img [4096];
    int nn = 1;
    int k  = 1;
    int win_cnt = 0;
    logic signed [DWIDTH-1:0] first_p0, first_p24, last_p0, last_p24;

    function automatic logic [F*F*DWIDTH-1:0] flat_pixels();
        logic [F*F*DWIDTH-1:0] f;
        for (int i = 0; i < F*F; i++) f[i*DWIDTH +: DWIDTH] = pixel[i];
        return f;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_window(input int kk, input logic [F*F*DWIDTH-1:0] obs,
                                input logic [F*F*DWIDTH-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL window after pixel %0d: got %h expected %h", kk, obs, exp);
        end
    endtask

    // One clock cycle of stimulus; outputs are checked on the following falling edge.
    task automatic step(input bit v, input logic signed [DWIDTH-1:0] d);
        bit acc;
        bit exp_valid;
        int r, c;
        logic [F*F*DWIDTH-1:0] exp_flat;
        in_valid = v;
        in_data  = d;
        #1;
        check("in_ready", in_ready, (nn >= F && k < nn*nn));
        acc = v && in_ready;
        if (acc) img[k] = d;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        r = k / nn;
        c = k % nn;
        exp_valid = acc && (r >= F-1) && (c >= F-1);
        exp_flat = '0;
        if (exp_valid) begin
            for (int i = 0; i < F*F; i++)
                exp_flat[i*DWIDTH +: DWIDTH] = img[(r-F+1+i/F)*nn + (c-F+1+i%F)];
        end
        check("out_valid", out_valid, exp_valid);
        check("done", done, acc && (k == nn*nn-1));
        check_window(k, flat_pixels(), exp_flat);
        if (out_valid) begin
            if (win_cnt == 0) begin
                first_p0  = pixel[0];
                first_p24 = pixel[F*F-1];
            end
            last_p0  = pixel[0];
            last_p24 = pixel[F*F-1];
            win_cnt++;
        end
        if (acc) k++;
    endtask

    task automatic start_frame(input int n);
        start    = 1'b1;
        img_size = LWIDTH'(n);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        nn = n;
        k  = 0;
        win_cnt = 0;
        check("busy_after_start", busy, 1);
        check("done_after_start", done, (n < F));
        check("valid_after_start", out_valid, 0);
    endtask

    task automatic run_frame(input int n, input bit ramp, input bit gaps, input int start_at);
        int guard;
        bit v;
        guard = 0;
        start_frame(n);
        while (nn >= F && k < nn*nn && guard < 1000) begin
            v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (guard == start_at) begin
                start    = 1'b1;
                img_size = LWIDTH'(4);
            end
            step(v, ramp ? DWIDTH'(k) : DWIDTH'($urandom));
            start = 1'b0;
            guard++;
        end
        if (n >= F) check("frame_complete", k, n*n);
        step(1'b0, '0);
        check("busy_idle", busy, 0);
        check("window_count", win_cnt, (n >= F) ? (n-F+1)*(n-F+1) : 0);
    endtask

    initial begin
        int guard;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_done", done, 0);
        check_window(-1, flat_pixels(), '0);
        xrst = 1'b1;
        @(negedge clk);

        // N=5 ramp: one window, pixel[i] = i, done together with out_valid
        run_frame(5, 1'b1, 1'b0, -1);
        check("n5_p0", last_p0, 0);
        check("n5_p24", last_p24, 24);

        // N=8 ramp, continuous and then with random in_valid gaps
        for (int pass = 0; pass < 2; pass++) begin
            run_frame(8, 1'b1, pass[0], -1);
            check("n8_first_p0", first_p0, 0);
            check("n8_first_p24", first_p24, 36);
            check("n8_last_p0", last_p0, 27);
            check("n8_last_p24", last_p24, 63);
        end

        // Random data, random gaps, and a start pulse in the middle of the frame
        run_frame(8, 1'b0, 1'b1, 20);

        // Frame smaller than the window
        run_frame(4, 1'b1, 1'b0, -1);

        // Asynchronous reset 30 pixels into an N=8 frame
        start_frame(8);
        guard = 0;
        while (k < 30 && guard < 100) begin
            step(1'b1, DWIDTH'(k));
            guard++;
        end
        check("pre_reset_count", k, 30);
        check("pre_reset_busy", busy, 1);
        #2;
        xrst = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_done", done, 0);
        check_window(-2, flat_pixels(), '0);
        @(negedge clk);
        @(negedge clk);
        xrst = 1'b1;
        nn = 1;
        k  = 1;
        @(negedge clk);

        run_frame(5, 1'b1, 1'b0, -1);
        check("post_rst_p0", last_p0, 0);
        check("post_rst_p24", last_p24, 24);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
